// File: rtl/timer_pkg.sv
// timer_pkg: shared types and register map for multi_timer_controller.
package timer_pkg;
    typedef logic [31:0] Word_t;
    typedef logic [3:0] ByteMask_t;

    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } TimerCtrl_t;

    localparam logic [3:0] TIMER_REG_COUNT       = 4'h0;
    localparam logic [3:0] TIMER_REG_COMPARE     = 4'h4;
    localparam logic [3:0] TIMER_REG_CTRL        = 4'h8;
    localparam logic [3:0] TIMER_REG_STATUS      = 4'hC;
    localparam logic [8:0] TIMER_REG_IRQ_PENDING = 9'h100;
    localparam int         TIMER_CH_STRIDE       = 'h10;

    function automatic Word_t apply_mask(Word_t old, Word_t wdata, ByteMask_t mask);
        Word_t r = old;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[8*b+:8] = wdata[8*b+:8];
        return r;
    endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer channel with compare match, reload/one-shot, W1C status and irq.
// The PWM comparator exists only when TIMER_PWM_EN is defined.
module timer_channel
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       wr_count,
    input  logic       wr_compare,
    input  logic       wr_ctrl,
    input  logic       wr_status,
    input  Word_t      wdata,
    input  ByteMask_t  mask,
    output Word_t      count,
    output Word_t      compare,
    output TimerCtrl_t ctrl,
    output logic       match,
    output logic       irq,
    output logic       pwm
);
    logic adv, hit, clear, ctrl_wr;
    Word_t count_nxt;
    TimerCtrl_t ctrl_nxt;

    // Match checks use the pre-edge COMPARE; a bus write to COUNT overrides the tick.
    always_comb begin
        adv = tick & ctrl.en;
        hit = adv & (count == compare);
        clear = wr_status & mask[0] & wdata[0];
        ctrl_wr = wr_ctrl & mask[0];
        count_nxt = wr_count ? apply_mask(count, wdata, mask) :
                    !adv ? count :
                    !hit ? count + 32'd1 :
                    ctrl.auto_reload ? '0 : count;
        ctrl_nxt = ctrl_wr ? TimerCtrl_t'(wdata[2:0]) :
                   '{auto_reload: ctrl.auto_reload, irq_en: ctrl.irq_en,
                     en: ctrl.en & ~(hit & ~ctrl.auto_reload)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            compare <= '0;
            ctrl    <= '0;
            match   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            count   <= count_nxt;
            compare <= wr_compare ? apply_mask(compare, wdata, mask) : compare;
            ctrl    <= ctrl_nxt;
            match   <= hit | (match & ~clear);
            irq     <= match & ctrl.irq_en;
        end
    end

`ifdef TIMER_PWM_EN
    always_ff @(posedge clk) pwm <= rst_n & ctrl.en & (count < compare);
`else
    assign pwm = 1'b0;
`endif
endmodule

// File: rtl/multi_timer_controller.sv
// multi_timer_controller: N-channel 32-bit timer bus slave with shared prescaler and irq vector.
// Define TIMER_PWM_EN to build the per-channel PWM outputs.
module multi_timer_controller
    import timer_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int PRESCALE   = 10,
    parameter int BASE_IRQ   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_read,
    input  logic                  bus_write,
    input  logic [31:0]           bus_address,
    input  Word_t                 bus_data_wr,
    input  ByteMask_t             bus_mask,
    output Word_t                 bus_data_rd,
    output logic                  bus_stall,
    output logic [N_CHANNELS-1:0] irq,
    output logic [N_CHANNELS-1:0] pwm
);
    logic [31:0] pre;
    logic tick;
    logic [8:0] off;
    Word_t count_a [N_CHANNELS];
    Word_t compare_a [N_CHANNELS];
    TimerCtrl_t ctrl_a [N_CHANNELS];
    logic [N_CHANNELS-1:0] match_v, irq_v, pend;
    logic unused_addr;

    assign off = bus_address[8:0];
    assign tick = pre == 32'(PRESCALE - 1);
    assign bus_stall = 1'b0;
    assign unused_addr = ^bus_address[31:9];

    always_ff @(posedge clk) pre <= (!rst_n || tick) ? '0 : pre + 32'd1;

    genvar g;
    generate
        for (g = 0; g < N_CHANNELS; g++) begin : g_ch
            logic sel;
            assign sel = bus_write & ~off[8] & (off[7:4] == 4'(g));
            timer_channel u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .tick       (tick),
                .wr_count   (sel & (off[3:0] == TIMER_REG_COUNT)),
                .wr_compare (sel & (off[3:0] == TIMER_REG_COMPARE)),
                .wr_ctrl    (sel & (off[3:0] == TIMER_REG_CTRL)),
                .wr_status  (sel & (off[3:0] == TIMER_REG_STATUS)),
                .wdata      (bus_data_wr),
                .mask       (bus_mask),
                .count      (count_a[g]),
                .compare    (compare_a[g]),
                .ctrl       (ctrl_a[g]),
                .match      (match_v[g]),
                .irq        (irq_v[g]),
                .pwm        (pwm[g])
            );
            assign irq[(g + BASE_IRQ) % N_CHANNELS] = irq_v[g];
            assign pend[g] = match_v[g] & ctrl_a[g].irq_en;
        end
    endgenerate

    always_comb begin
        bus_data_rd = '0;
        if (rst_n && bus_read) begin
            for (int c = 0; c < N_CHANNELS; c++)
                if (!off[8] && off[7:4] == 4'(c))
                    bus_data_rd = off[3:0] == TIMER_REG_COUNT   ? count_a[c] :
                                  off[3:0] == TIMER_REG_COMPARE ? compare_a[c] :
                                  off[3:0] == TIMER_REG_CTRL    ? 32'(ctrl_a[c]) :
                                  off[3:0] == TIMER_REG_STATUS  ? 32'(match_v[c]) : '0;
            if (off == TIMER_REG_IRQ_PENDING) bus_data_rd = 32'(pend);
        end
    end
endmodule
